// File: rtl/timer_input_sel.sv
// Registered N-to-1 timer input selector.
// Manual select with deferred switching, or fixed-priority auto select.
module timer_input_sel #(
  parameter int NUM_CH   = 4,
  parameter int WIDTH    = 8,
  parameter int SELW     = 2,
  parameter int AUTO_SEL = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [SELW-1:0]         sel,
  input  logic                    sel_load,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_valid,
  output logic [NUM_CH-1:0]       in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SELW-1:0]         active_ch,
  output logic                    sel_err
);

  typedef enum logic [1:0] {
    IDLE,
    FULL,
    SWITCH
  } state_t;

  state_t state, state_n;

  logic [SELW-1:0]  pend_sel;
  logic [SELW-1:0]  win;
  logic [SELW-1:0]  src;
  logic [WIDTH-1:0] src_data;
  logic             pend;
  logic             can_load;
  logic             any_v;
  logic             xfer;
  logic             sel_big;
  logic             sel_ok;
  logic             sel_bad;
  logic             apply;
  logic             is_auto;

  assign is_auto  = (AUTO_SEL != 0);
  assign pend     = (state == SWITCH);
  assign can_load = !out_valid | out_ready;
  assign sel_big  = (int'(sel) >= NUM_CH);
  assign sel_ok   = sel_load & !sel_big & !is_auto;
  assign sel_bad  = sel_load & sel_big & !is_auto;
  // A fresh request while pending re-arms the wait instead of applying.
  assign apply    = pend & can_load & !sel_ok;
  assign src      = is_auto ? win : active_ch;
  assign xfer     = |(in_valid & in_ready);

  always_comb begin
    win   = '0;
    any_v = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (in_valid[i]) begin
        win   = SELW'(i);
        any_v = 1'b1;
      end
    end
  end

  always_comb begin
    in_ready = '0;
    src_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (SELW'(i) == src) begin
        src_data = in_data[i*WIDTH +: WIDTH];
        if (is_auto) begin
          in_ready[i] = can_load & any_v & rst_n;
        end else begin
          in_ready[i] = can_load & !pend & rst_n;
        end
      end
    end
  end

  always_comb begin
    state_n = state;
    if (sel_ok) begin
      state_n = SWITCH;
    end else begin
      unique case (state)
        IDLE: begin
          if (xfer) state_n = FULL;
        end
        FULL: begin
          if (xfer)           state_n = FULL;
          else if (out_ready) state_n = IDLE;
        end
        SWITCH: begin
          if (apply) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_data  <= '0;
      out_valid <= 1'b0;
      active_ch <= '0;
      pend_sel  <= '0;
      sel_err   <= 1'b0;
    end else begin
      state   <= state_n;
      sel_err <= sel_bad;
      if (sel_ok) pend_sel <= sel;
      if (apply) begin
        active_ch <= pend_sel;
      end else if (is_auto && xfer) begin
        active_ch <= win;
      end
      if (xfer) begin
        out_data  <= src_data;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
